// File: rtl/mul_div_unit.sv
// Iterative multiply/divide unit holding the HI/LO registers.
// Define MDU_FAST_MUL_EN to compute MULT/MULTU in a single cycle.
module mul_div_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] rs_data,
    input  logic [WIDTH-1:0] rt_data,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

`ifdef MDU_FAST_MUL_EN
    localparam bit FAST_MUL = 1'b1;
`else
    localparam bit FAST_MUL = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

    state_t state, state_nx;

    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] a, q, m;
    logic             neg_res, neg_rem, op_div, dz;

    logic             is_mul, is_div, is_signed, last;
    logic [WIDTH-1:0] rs_abs, rt_abs;
    logic [WIDTH:0]   mul_sum, div_shift;
    logic [WIDTH-1:0] div_sub;
    logic             div_ge;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0] quo_fix, rem_fix;

    assign is_mul    = (op == 3'd0) || (op == 3'd1);
    assign is_div    = (op == 3'd2) || (op == 3'd3);
    assign is_signed = (op == 3'd0) || (op == 3'd2);
    assign rs_abs    = (is_signed && rs_data[WIDTH-1]) ? -rs_data : rs_data;
    assign rt_abs    = (is_signed && rt_data[WIDTH-1]) ? -rt_data : rt_data;
    assign last      = (cnt == CNT_W'(WIDTH - 1));
    assign busy      = (state != IDLE);

    // Shift-add: multiplier in q, partial product accumulates in a
    assign mul_sum   = {1'b0, a} + (q[0] ? {1'b0, m} : '0);
    // Restoring divide: remainder in a, dividend shifts out of q
    assign div_shift = {a, q[WIDTH-1]};
    assign div_ge    = (div_shift >= {1'b0, m});
    assign div_sub   = div_shift[WIDTH-1:0] - m;

    assign prod_fix  = neg_res ? -{a, q} : {a, q};
    assign quo_fix   = neg_res ? -q : q;
    assign rem_fix   = neg_rem ? -a : a;

`ifdef MDU_FAST_MUL_EN
    logic [2*WIDTH-1:0] fast_prod;
    assign fast_prod = {{WIDTH{1'b0}}, rs_abs} * {{WIDTH{1'b0}}, rt_abs};
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (start && is_mul)      state_nx = FAST_MUL ? FIX : MUL;
                else if (start && is_div) state_nx = DIV;
            end
            MUL:     if (last) state_nx = FIX;
            DIV:     if (dz || last) state_nx = FIX;
            FIX:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt     <= '0;
            a       <= '0;
            q       <= '0;
            m       <= '0;
            neg_res <= 1'b0;
            neg_rem <= 1'b0;
            op_div  <= 1'b0;
            dz      <= 1'b0;
            done    <= 1'b0;
            hi      <= '0;
            lo      <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start && (is_mul || is_div)) begin
                        cnt     <= '0;
                        neg_res <= is_signed && (rs_data[WIDTH-1] ^ rt_data[WIDTH-1]);
                        neg_rem <= is_signed && rs_data[WIDTH-1];
                        op_div  <= is_div;
                        dz      <= 1'b0;
                        m       <= is_mul ? rs_abs : rt_abs;
                        if (is_mul) begin
`ifdef MDU_FAST_MUL_EN
                            {a, q} <= fast_prod;
`else
                            a <= '0;
                            q <= rt_abs;
`endif
                        end else if (rt_data == '0) begin
                            a  <= rs_data;
                            q  <= '1;
                            dz <= 1'b1;
                        end else begin
                            a <= '0;
                            q <= rs_abs;
                        end
                    end else if (start && op == 3'd4) begin
                        hi <= rs_data;
                    end else if (start && op == 3'd5) begin
                        lo <= rs_data;
                    end
                end
                MUL: begin
                    {a, q} <= {mul_sum, q[WIDTH-1:1]};
                    cnt    <= cnt + CNT_W'(1);
                end
                DIV: begin
                    if (!dz) begin
                        a   <= div_ge ? div_sub : div_shift[WIDTH-1:0];
                        q   <= {q[WIDTH-2:0], div_ge};
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                FIX: begin
                    done <= 1'b1;
                    if (dz) begin
                        hi <= a;
                        lo <= q;
                    end else if (op_div) begin
                        hi <= rem_fix;
                        lo <= quo_fix;
                    end else begin
                        {hi, lo} <= prod_fix;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit against an arithmetic reference model.
module tb_mul_div_unit;

`ifdef MDU_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = 33;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  op = 3'd7;
    logic [31:0] rs_data = '0;
    logic [31:0] rt_data = '0;
    logic        busy, done;
    logic [31:0] hi, lo;

    int checks = 0;
    int errors = 0;

    mul_div_unit #(.WIDTH(32), .CNT_W(6)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op),
        .rs_data(rs_data), .rt_data(rt_data),
        .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Returns {hi, lo} from the architectural definition of each op
    function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        longint sx, sy, qt, rm;
        logic [63:0] ux, uy;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = {32'd0, x};
        uy = {32'd0, y};
        if (o == 3'd0) return 64'(sx * sy);
        if (o == 3'd1) return ux * uy;
        if (y == 32'd0) return {x, 32'hFFFF_FFFF};
        if (o == 3'd2) begin
            qt = sx / sy;
            rm = sx % sy;
            return {rm[31:0], qt[31:0]};
        end
        return {32'(ux % uy), 32'(ux / uy)};
    endfunction

    function automatic int latency(input logic [2:0] o, input logic [31:0] y);
        if (o <= 3'd1) return MUL_LAT;
        if (y == 32'd0) return 2;
        return 33;
    endfunction

    task automatic run(input string tag, input logic [2:0] o, input logic [31:0] x,
                       input logic [31:0] y, input bit inject);
        logic [63:0] exp;
        logic [31:0] hi0, lo0;
        int k;
        bit held;
        exp = model(o, x, y);
        @(negedge clk);
        hi0 = hi;
        lo0 = lo;
        start = 1'b1;
        op = o;
        rs_data = x;
        rt_data = y;
        @(negedge clk);
        start = 1'b0;
        rs_data = $urandom;
        rt_data = $urandom;
        k = 0;
        held = 1'b1;
        while (!done && k < 100) begin
            if (!busy || hi !== hi0 || lo !== lo0) held = 1'b0;
            if (inject && k == 4) begin
                start = 1'b1;
                op = 3'd5;
                rs_data = 32'hAA;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            k++;
        end
        start = 1'b0;
        chk({tag, "_lat"}, 64'(k), 64'(latency(o, y)));
        chk({tag, "_held"}, 64'(held), 64'd1);
        chk({tag, "_hilo"}, {hi, lo}, exp);
        @(negedge clk);
        chk({tag, "_pulse"}, {62'd0, busy, done}, 64'd0);
    endtask

    task automatic mt(input string tag, input logic [2:0] o, input logic [31:0] x);
        logic [63:0] exp;
        exp = (o == 3'd4) ? {x, lo} : (o == 3'd5) ? {hi, x} : {hi, lo};
        @(negedge clk);
        start = 1'b1;
        op = o;
        rs_data = x;
        @(negedge clk);
        start = 1'b0;
        chk({tag, "_hilo"}, {hi, lo}, exp);
        chk({tag, "_idle"}, {62'd0, busy, done}, 64'd0);
    endtask

    initial begin
        logic [2:0] ro;
        logic [31:0] ra, rb;
        bit seen;

        @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_hilo", {hi, lo}, 64'd0);
        @(negedge clk);
        reset = 1'b0;

        run("mult_neg", 3'd0, 32'hFFFF_FFFD, 32'd5, 1'b0);
        chk("mult_neg_k", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFF1);
        run("multu_max", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        chk("multu_max_k", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
        run("div_neg", 3'd2, 32'hFFFF_FFF9, 32'd2, 1'b0);
        chk("div_neg_k", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
        run("div_ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        chk("div_ovf_k", {hi, lo}, 64'h0000_0000_8000_0000);
        run("divu_zero", 3'd3, 32'd7, 32'd0, 1'b0);
        chk("divu_zero_k", {hi, lo}, 64'h0000_0007_FFFF_FFFF);
        run("div_zero", 3'd2, 32'hFFFF_FF00, 32'd0, 1'b0);
        mt("mthi", 3'd4, 32'h1234);
        mt("mtlo", 3'd5, 32'h5678);
        mt("nop6", 3'd6, 32'hDEAD);
        mt("nop7", 3'd7, 32'hBEEF);
        run("divu_inj", 3'd3, 32'd100, 32'd7, 1'b1);
        chk("divu_inj_k", {hi, lo}, {32'd2, 32'd14});
        run("div_remsign", 3'd2, 32'd7, 32'hFFFF_FFFE, 1'b0);

        // Reset in the middle of a multiply
        @(negedge clk);
        start = 1'b1;
        op = 3'd0;
        rs_data = 32'd1234;
        rt_data = 32'd5678;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        reset = 1'b1;
        #1;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_done", 64'(done), 64'd0);
        chk("abort_hilo", {hi, lo}, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (done || busy) seen = 1'b1;
        end
        chk("abort_quiet", 64'(seen), 64'd0);
        run("after_abort", 3'd1, 32'd300, 32'd7, 1'b0);

        for (int i = 0; i < 30; i++) begin
            ro = 3'($urandom_range(0, 3));
            ra = $urandom;
            rb = $urandom;
            if (i % 7 == 3) rb = 32'd0;
            if (i % 5 == 1) rb = 32'($urandom_range(1, 15));
            if (i % 11 == 2) ra = 32'h8000_0000;
            run("rand", ro, ra, rb, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
